dport_mux_n: RTL

//  - Parametrised successor to the two-way data-port splitter: routes one CPU data-port

---
 rtl/dport_mux_n.sv | 143 ++++++++++++++
 1 files changed

// File: rtl/dport_mux_n.sv
// Purpose: route one CPU data-port request stream to NUM_TGT target ports by address window,
//          answering unmapped addresses internally with an error response.
// Latency: requests and accepts are combinational (zero added cycles); unmapped error response one cycle after accept.
// Backpressure: accept drops when the selected target stalls, when a target switch would break
//               response ordering, or when the outstanding counter is full.
// Ports: mem_* = upstream CPU dport (request in, response out); tgt_* = packed per-target
//        request fan-out and response inputs, entry i in bits [i*W +: W].
module dport_mux_n #(
   parameter int                    NUM_TGT  = 2,
   parameter logic [NUM_TGT*32-1:0] TGT_BASE = {32'h0, 32'h80000000},
   parameter logic [NUM_TGT*32-1:0] TGT_MASK = {32'h80000000, 32'hFFFF0000},
   parameter int                    PEND_W   = 5
) (
   input  logic                    clk_i,
   input  logic                    rst_ni,
   input  logic [31:0]             mem_addr_i,
   input  logic [31:0]             mem_data_wr_i,
   input  logic                    mem_rd_i,
   input  logic [3:0]              mem_wr_i,
   input  logic                    mem_cacheable_i,
   input  logic [10:0]             mem_req_tag_i,
   input  logic                    mem_invalidate_i,
   input  logic                    mem_writeback_i,
   input  logic                    mem_flush_i,
   output logic [31:0]             mem_data_rd_o,
   output logic                    mem_accept_o,
   output logic                    mem_ack_o,
   output logic                    mem_error_o,
   output logic [10:0]             mem_resp_tag_o,
   output logic [NUM_TGT*32-1:0]   tgt_addr_o,
   output logic [NUM_TGT*32-1:0]   tgt_data_wr_o,
   output logic [NUM_TGT-1:0]      tgt_rd_o,
   output logic [NUM_TGT*4-1:0]    tgt_wr_o,
   output logic [NUM_TGT-1:0]      tgt_cacheable_o,
   output logic [NUM_TGT*11-1:0]   tgt_req_tag_o,
   output logic [NUM_TGT-1:0]      tgt_invalidate_o,
   output logic [NUM_TGT-1:0]      tgt_writeback_o,
   output logic [NUM_TGT-1:0]      tgt_flush_o,
   input  logic [NUM_TGT-1:0]      tgt_accept_i,
   input  logic [NUM_TGT-1:0]      tgt_ack_i,
   input  logic [NUM_TGT-1:0]      tgt_error_i,
   input  logic [NUM_TGT*32-1:0]   tgt_data_rd_i,
   input  logic [NUM_TGT*11-1:0]   tgt_resp_tag_i
);

   // Index NUM_TGT is the internal error responder.
   localparam int                SEL_W    = $clog2(NUM_TGT + 1);
   localparam logic [SEL_W-1:0]  UNMAPPED = SEL_W'(NUM_TGT);
   localparam logic [PEND_W-1:0] PEND_MAX = {PEND_W{1'b1}};

   logic [SEL_W-1:0]  sel_w;
   logic [SEL_W-1:0]  sel_q;
   logic [PEND_W-1:0] pending_q;
   logic              err_v_q;
   logic [10:0]       err_tag_q;
   logic              tgt_acc_w;
   logic              hold_w;
   logic              request_w;
   logic              fire_w;
   logic              unmapped_w;
   logic [NUM_TGT-1:0] go_w;

   // Address decode: walk downwards so the lowest matching window wins.
   always_comb begin
      sel_w = UNMAPPED;
      for (int i = NUM_TGT - 1; i >= 0; i--) begin
         if ((mem_addr_i & TGT_MASK[i*32 +: 32]) == TGT_BASE[i*32 +: 32])
            sel_w = SEL_W'(i);
      end
   end

   assign unmapped_w = (sel_w == UNMAPPED);

   // The error responder always accepts; loop avoids indexing tgt_accept_i out of range.
   always_comb begin
      tgt_acc_w = 1'b1;
      for (int i = 0; i < NUM_TGT; i++) begin
         if (sel_w == SEL_W'(i))
            tgt_acc_w = tgt_accept_i[i];
      end
   end

   // Stall on a target switch while responses are outstanding so they cannot
   // return out of order, and stall when the counter cannot count any higher.
   assign hold_w       = ((pending_q != '0) && (sel_q != sel_w)) || (pending_q == PEND_MAX);
   assign request_w    = mem_rd_i | (|mem_wr_i) | mem_flush_i | mem_invalidate_i | mem_writeback_i;
   assign mem_accept_o = !hold_w && tgt_acc_w;
   assign fire_w       = request_w && mem_accept_o;

   // Request fan-out: operation strobes are gated per target, payload is broadcast.
   always_comb begin
      for (int i = 0; i < NUM_TGT; i++) begin
         go_w[i]               = (sel_w == SEL_W'(i)) && !hold_w;
         tgt_rd_o[i]           = mem_rd_i & go_w[i];
         tgt_wr_o[i*4 +: 4]    = go_w[i] ? mem_wr_i : 4'b0000;
         tgt_invalidate_o[i]   = mem_invalidate_i & go_w[i];
         tgt_writeback_o[i]    = mem_writeback_i & go_w[i];
         tgt_flush_o[i]        = mem_flush_i & go_w[i];
         tgt_cacheable_o[i]    = mem_cacheable_i;
         tgt_addr_o[i*32 +: 32]    = mem_addr_i;
         tgt_data_wr_o[i*32 +: 32] = mem_data_wr_i;
         tgt_req_tag_o[i*11 +: 11] = mem_req_tag_i;
      end
   end

   // Response mux follows the target of the most recent accepted request.
   always_comb begin
      mem_ack_o      = err_v_q;
      mem_error_o    = err_v_q;
      mem_data_rd_o  = 32'h0;
      mem_resp_tag_o = err_tag_q;
      for (int i = 0; i < NUM_TGT; i++) begin
         if (sel_q == SEL_W'(i)) begin
            mem_ack_o      = tgt_ack_i[i];
            mem_error_o    = tgt_error_i[i];
            mem_data_rd_o  = tgt_data_rd_i[i*32 +: 32];
            mem_resp_tag_o = tgt_resp_tag_i[i*11 +: 11];
         end
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         pending_q <= '0;
         sel_q     <= '0;
         err_v_q   <= 1'b0;
         err_tag_q <= 11'h0;
      end else begin
         // One error response per unmapped accept, the cycle after it.
         err_v_q <= fire_w && unmapped_w;
         if (fire_w && unmapped_w)
            err_tag_q <= mem_req_tag_i;
         if (fire_w)
            sel_q <= sel_w;
         // A stray ack with nothing outstanding is passed on but not counted.
         if (fire_w && !mem_ack_o)
            pending_q <= pending_q + PEND_W'(1);
         else if (!fire_w && mem_ack_o && (pending_q != '0))
            pending_q <= pending_q - PEND_W'(1);
      end
   end

endmodule
